// File: rtl/lock_table_manager.sv
// Lock table: round-robin acquire arbitration, duplicate/full rejection, and release handling.
// Optional LOCK_OWNER_CHECK_EN: slots remember the granted requester and releases must match it.
module lock_table_manager #(
  parameter int unsigned MAX_LOCK_KEYS = 4,
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned KEY_WIDTH     = 32,
  parameter int unsigned ID_W          = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 acq_req,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]       acq_key,
  output logic [NUM_REQ-1:0]                 acq_grant,
  output logic [NUM_REQ-1:0]                 acq_deny,
  input  logic                               rel_valid,
  input  logic [KEY_WIDTH-1:0]               rel_key,
  input  logic [ID_W-1:0]                    rel_id,
  output logic                               rel_done,
  output logic                               rel_miss,
  output logic [MAX_LOCK_KEYS*KEY_WIDTH-1:0] locked_key,
  output logic [MAX_LOCK_KEYS-1:0]           lock_valid,
  output logic [$clog2(MAX_LOCK_KEYS+1)-1:0] num_locked,
  output logic                               table_full
);

  localparam int unsigned SLOT_W = (MAX_LOCK_KEYS > 1) ? $clog2(MAX_LOCK_KEYS) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_LOCK_KEYS + 1);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t                             state, state_d;
  logic [ID_W-1:0]                    rr, rr_d;
  logic [ID_W-1:0]                    winner, winner_d;
  logic [KEY_WIDTH-1:0]               key_q, key_d;
  logic                               hit_q, hit_d;
  logic [SLOT_W-1:0]                  free_q, free_d;
  logic [MAX_LOCK_KEYS-1:0]           valid_d;
  logic [MAX_LOCK_KEYS*KEY_WIDTH-1:0] keys_d;
  logic [NUM_REQ-1:0]                 grant_d, deny_d;
  logic                               done_d, miss_d;
  logic [CNT_W-1:0]                   cnt_d;
  logic [NUM_REQ-1:0]                 eff_req;
  logic                               rel_take;
  logic                               rel_hit;
  logic                               req_found;
  logic                               free_found;
  logic [ID_W-1:0]                    pick;

`ifdef LOCK_OWNER_CHECK_EN
  logic [MAX_LOCK_KEYS-1:0][ID_W-1:0] owner, owner_d;
`else
  logic unused_rel_id;
  assign unused_rel_id = ^rel_id;
`endif

  // Next-state, table update and response pulses
  always_comb begin
    state_d    = state;
    rr_d       = rr;
    winner_d   = winner;
    key_d      = key_q;
    hit_d      = hit_q;
    free_d     = free_q;
    valid_d    = lock_valid;
    keys_d     = locked_key;
    grant_d    = '0;
    deny_d     = '0;
    done_d     = 1'b0;
    miss_d     = 1'b0;
    cnt_d      = '0;
    rel_hit    = 1'b0;
    req_found  = 1'b0;
    free_found = 1'b0;
    pick       = winner;
`ifdef LOCK_OWNER_CHECK_EN
    owner_d    = owner;
`endif
    // A requester still seeing its own pulse must not be re-served on that edge
    eff_req  = acq_req & ~(acq_grant | acq_deny);
    rel_take = rel_valid & ~(rel_done | rel_miss);

    case (state)
      IDLE: begin
        if (rel_take) begin
          for (int s = 0; s < int'(MAX_LOCK_KEYS); s++) begin
            if (!rel_hit && lock_valid[s] &&
                locked_key[s*KEY_WIDTH +: KEY_WIDTH] == rel_key
`ifdef LOCK_OWNER_CHECK_EN
                && owner[s] == rel_id
`endif
                ) begin
              rel_hit    = 1'b1;
              valid_d[s] = 1'b0;
            end
          end
          done_d = rel_hit;
          miss_d = !rel_hit;
        end else if (|eff_req) begin
          for (int unsigned o = 0; o < NUM_REQ; o++) begin
            if (!req_found && eff_req[(32'(rr) + o) % NUM_REQ]) begin
              req_found = 1'b1;
              pick      = ID_W'((32'(rr) + o) % NUM_REQ);
            end
          end
          winner_d = pick;
          key_d    = acq_key[32'(pick)*KEY_WIDTH +: KEY_WIDTH];
          state_d  = CHECK;
        end
      end
      CHECK: begin
        hit_d  = 1'b0;
        free_d = '0;
        for (int s = 0; s < int'(MAX_LOCK_KEYS); s++) begin
          if (lock_valid[s] && locked_key[s*KEY_WIDTH +: KEY_WIDTH] == key_q) hit_d = 1'b1;
          if (!free_found && !lock_valid[s]) begin
            free_found = 1'b1;
            free_d     = SLOT_W'(s);
          end
        end
        state_d = RESP;
      end
      RESP: begin
        if (hit_q || table_full) begin
          deny_d[winner] = 1'b1;
        end else begin
          keys_d[32'(free_q)*KEY_WIDTH +: KEY_WIDTH] = key_q;
          valid_d[free_q]  = 1'b1;
          grant_d[winner]  = 1'b1;
`ifdef LOCK_OWNER_CHECK_EN
          owner_d[free_q]  = winner;
`endif
        end
        rr_d    = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int s = 0; s < int'(MAX_LOCK_KEYS); s++) cnt_d = cnt_d + CNT_W'(valid_d[s]);
  end

  // State, table and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr         <= '0;
      winner     <= '0;
      key_q      <= '0;
      hit_q      <= 1'b0;
      free_q     <= '0;
      lock_valid <= '0;
      locked_key <= '0;
      acq_grant  <= '0;
      acq_deny   <= '0;
      rel_done   <= 1'b0;
      rel_miss   <= 1'b0;
      num_locked <= '0;
      table_full <= 1'b0;
`ifdef LOCK_OWNER_CHECK_EN
      owner      <= '0;
`endif
    end else begin
      state      <= state_d;
      rr         <= rr_d;
      winner     <= winner_d;
      key_q      <= key_d;
      hit_q      <= hit_d;
      free_q     <= free_d;
      lock_valid <= valid_d;
      locked_key <= keys_d;
      acq_grant  <= grant_d;
      acq_deny   <= deny_d;
      rel_done   <= done_d;
      rel_miss   <= miss_d;
      num_locked <= cnt_d;
      table_full <= &valid_d;
`ifdef LOCK_OWNER_CHECK_EN
      owner      <= owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_lock_table_manager.sv
// Directed bench for lock_table_manager with hand-computed expectations.
module tb_lock_table_manager;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   acq_req;
  logic [63:0]  acq_key;
  logic [1:0]   acq_grant, acq_deny;
  logic         rel_valid;
  logic [31:0]  rel_key;
  logic         rel_id;
  logic         rel_done, rel_miss;
  logic [127:0] locked_key;
  logic [3:0]   lock_valid;
  logic [2:0]   num_locked;
  logic         table_full;

  int nchk = 0;
  int nerr = 0;

  lock_table_manager dut (
    .clk(clk), .reset(reset),
    .acq_req(acq_req), .acq_key(acq_key), .acq_grant(acq_grant), .acq_deny(acq_deny),
    .rel_valid(rel_valid), .rel_key(rel_key), .rel_id(rel_id),
    .rel_done(rel_done), .rel_miss(rel_miss),
    .locked_key(locked_key), .lock_valid(lock_valid),
    .num_locked(num_locked), .table_full(table_full)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0; acq_req = '0; rel_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one acquire until answered (bounded), then leaves one idle cycle
  task automatic do_acq(input int id, input logic [31:0] key,
                        output int lat, output logic g, output logic d);
    acq_key[id*32 +: 32] = key;
    acq_req[id] = 1'b1;
    lat = 0; g = 1'b0; d = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (acq_grant[id] | acq_deny[id]) begin
        g = acq_grant[id]; d = acq_deny[id]; lat = c;
        break;
      end
    end
    acq_req[id] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_rel(input logic [31:0] key, input logic id,
                        output int lat, output logic dn, output logic ms);
    rel_key = key; rel_id = id; rel_valid = 1'b1;
    lat = 0; dn = 1'b0; ms = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rel_done | rel_miss) begin
        dn = rel_done; ms = rel_miss; lat = c;
        break;
      end
    end
    rel_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; acq_req = '0; acq_key = '0; rel_valid = 1'b0; rel_key = '0; rel_id = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nchk++; if ({acq_grant, acq_deny, rel_done, rel_miss} !== 6'b0) begin nerr++; $display("FAIL reset_pulses: got %b want 000000", {acq_grant, acq_deny, rel_done, rel_miss}); end
    nchk++; if (lock_valid !== 4'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0000", lock_valid); end
    nchk++; if (locked_key !== 128'b0) begin nerr++; $display("FAIL reset_keys: got %h want 0", locked_key); end
    nchk++; if ({num_locked, table_full} !== 4'b0) begin nerr++; $display("FAIL reset_count: got %b want 0000", {num_locked, table_full}); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_grant();
    int lat; logic g, d;
    do_acq(0, 32'h0000_00AA, lat, g, d);
    nchk++; if ({g, d} !== 2'b10) begin nerr++; $display("FAIL first_grant: got g%b d%b want g1 d0", g, d); end
    nchk++; if (lat !== 3) begin nerr++; $display("FAIL first_latency: got %0d want 3", lat); end
    nchk++; if (lock_valid !== 4'b0001) begin nerr++; $display("FAIL first_valid: got %b want 0001", lock_valid); end
    nchk++; if (locked_key[31:0] !== 32'hAA) begin nerr++; $display("FAIL first_slot0: got %h want aa", locked_key[31:0]); end
    nchk++; if (num_locked !== 3'd1) begin nerr++; $display("FAIL first_count: got %0d want 1", num_locked); end
  endtask

  task automatic test_same_key();
    int t0, t1; logic g0, d1;
    apply_reset();
    t0 = 0; t1 = 0; g0 = 1'b0; d1 = 1'b0;
    acq_key = {32'h11, 32'h11};
    acq_req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (acq_req[0] && (acq_grant[0] | acq_deny[0])) begin g0 = acq_grant[0]; t0 = c; acq_req[0] = 1'b0; end
      if (acq_req[1] && (acq_grant[1] | acq_deny[1])) begin d1 = acq_deny[1]; t1 = c; acq_req[1] = 1'b0; end
      if (acq_req == 2'b00) break;
    end
    acq_req = '0;
    @(posedge clk); #1;
    nchk++; if ({g0, t0} !== {1'b1, 32'd3}) begin nerr++; $display("FAIL same_key_req0: got g%b at %0d want g1 at 3", g0, t0); end
    nchk++; if ({d1, t1} !== {1'b1, 32'd6}) begin nerr++; $display("FAIL same_key_req1: got d%b at %0d want d1 at 6", d1, t1); end
    nchk++; if ({num_locked, lock_valid} !== {3'd1, 4'b0001}) begin nerr++; $display("FAIL same_key_table: got %0d/%b want 1/0001", num_locked, lock_valid); end
  endtask

  task automatic test_full_and_release();
    int lat; logic g, d, dn, ms;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      do_acq(0, 32'(k), lat, g, d);
      nchk++; if ({g, lat} !== {1'b1, 32'd3}) begin nerr++; $display("FAIL fill_%0d: got g%b lat %0d want g1 lat 3", k, g, lat); end
    end
    nchk++; if ({lock_valid, num_locked, table_full} !== {4'b1111, 3'd4, 1'b1}) begin nerr++; $display("FAIL full_state: got %b/%0d/%b want 1111/4/1", lock_valid, num_locked, table_full); end
    do_acq(0, 32'h5, lat, g, d);
    nchk++; if ({g, d} !== 2'b01) begin nerr++; $display("FAIL full_deny: got g%b d%b want g0 d1", g, d); end
    do_rel(32'h2, 1'b0, lat, dn, ms);
    nchk++; if ({dn, ms, lat} !== {2'b10, 32'd1}) begin nerr++; $display("FAIL rel_2: got d%b m%b lat %0d want d1 m0 lat 1", dn, ms, lat); end
    nchk++; if ({lock_valid, num_locked, table_full} !== {4'b1101, 3'd3, 1'b0}) begin nerr++; $display("FAIL rel_2_state: got %b/%0d/%b want 1101/3/0", lock_valid, num_locked, table_full); end
    do_acq(1, 32'h5, lat, g, d);
    nchk++; if ({g, d} !== 2'b10) begin nerr++; $display("FAIL refill_grant: got g%b d%b want g1 d0", g, d); end
    nchk++; if ({locked_key[63:32], table_full} !== {32'h5, 1'b1}) begin nerr++; $display("FAIL refill_slot1: got %h full %b want 5 full 1", locked_key[63:32], table_full); end
  endtask

  task automatic test_rel_miss();
    int lat; logic dn, ms;
    do_rel(32'h99, 1'b0, lat, dn, ms);
    nchk++; if ({dn, ms} !== 2'b01) begin nerr++; $display("FAIL rel_miss: got d%b m%b want d0 m1", dn, ms); end
    nchk++; if (lock_valid !== 4'b1111) begin nerr++; $display("FAIL rel_miss_valid: got %b want 1111", lock_valid); end
    nchk++; if (locked_key !== {32'h4, 32'h3, 32'h5, 32'h1}) begin nerr++; $display("FAIL rel_miss_keys: got %h want 4/3/5/1", locked_key); end
  endtask

  task automatic test_back_to_back_release();
    rel_key = 32'h1; rel_id = 1'b0; rel_valid = 1'b1;
    @(posedge clk); #1;
    nchk++; if ({rel_done, rel_miss} !== 2'b10) begin nerr++; $display("FAIL b2b_first: got d%b m%b want d1 m0", rel_done, rel_miss); end
    rel_key = 32'h3;
    @(posedge clk); #1;
    nchk++; if ({rel_done, rel_miss} !== 2'b00) begin nerr++; $display("FAIL b2b_gap: got d%b m%b want d0 m0", rel_done, rel_miss); end
    @(posedge clk); #1;
    nchk++; if ({rel_done, rel_miss} !== 2'b10) begin nerr++; $display("FAIL b2b_second: got d%b m%b want d1 m0", rel_done, rel_miss); end
    rel_valid = 1'b0;
    @(posedge clk); #1;
    nchk++; if ({lock_valid, num_locked} !== {4'b1010, 3'd2}) begin nerr++; $display("FAIL b2b_state: got %b/%0d want 1010/2", lock_valid, num_locked); end
  endtask

  task automatic test_rel_priority();
    int lat, tr, ta; logic g, d, rd, ga;
    apply_reset();
    do_acq(0, 32'h33, lat, g, d);
    tr = 0; ta = 0; rd = 1'b0; ga = 1'b0;
    rel_key = 32'h33; rel_id = 1'b0; rel_valid = 1'b1;
    acq_key[63:32] = 32'h44; acq_req[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (rel_valid && (rel_done | rel_miss)) begin rd = rel_done; tr = c; rel_valid = 1'b0; end
      if (acq_req[1] && (acq_grant[1] | acq_deny[1])) begin ga = acq_grant[1]; ta = c; acq_req[1] = 1'b0; end
      if (!rel_valid && !acq_req[1]) break;
    end
    rel_valid = 1'b0; acq_req = '0;
    @(posedge clk); #1;
    nchk++; if ({rd, tr} !== {1'b1, 32'd1}) begin nerr++; $display("FAIL prio_release: got d%b at %0d want d1 at 1", rd, tr); end
    nchk++; if ({ga, ta} !== {1'b1, 32'd4}) begin nerr++; $display("FAIL prio_acquire: got g%b at %0d want g1 at 4", ga, ta); end
    nchk++; if ({locked_key[31:0], lock_valid} !== {32'h44, 4'b0001}) begin nerr++; $display("FAIL prio_table: got %h/%b want 44/0001", locked_key[31:0], lock_valid); end
  endtask

  task automatic test_owner();
    int lat; logic g, d, dn, ms;
    apply_reset();
    do_acq(1, 32'h7, lat, g, d);
    nchk++; if ({g, lock_valid} !== {1'b1, 4'b0001}) begin nerr++; $display("FAIL owner_lock: got g%b %b want g1 0001", g, lock_valid); end
    do_rel(32'h7, 1'b0, lat, dn, ms);
`ifdef LOCK_OWNER_CHECK_EN
    nchk++; if ({dn, ms, lock_valid} !== {2'b01, 4'b0001}) begin nerr++; $display("FAIL owner_wrong_id: got d%b m%b %b want d0 m1 0001", dn, ms, lock_valid); end
    do_rel(32'h7, 1'b1, lat, dn, ms);
    nchk++; if ({dn, ms, lock_valid} !== {2'b10, 4'b0000}) begin nerr++; $display("FAIL owner_right_id: got d%b m%b %b want d1 m0 0000", dn, ms, lock_valid); end
`else
    nchk++; if ({dn, ms, lock_valid} !== {2'b10, 4'b0000}) begin nerr++; $display("FAIL owner_ignored: got d%b m%b %b want d1 m0 0000", dn, ms, lock_valid); end
`endif
  endtask

  task automatic test_reset_in_resp();
    int lat; logic g, d;
    apply_reset();
    acq_key[31:0] = 32'h55; acq_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    acq_req = '0;
    @(posedge clk); #1;
    nchk++; if ({acq_grant, acq_deny} !== 4'b0) begin nerr++; $display("FAIL resp_reset_pulse: got %b want 0000", {acq_grant, acq_deny}); end
    nchk++; if ({lock_valid, num_locked} !== {4'b0, 3'd0}) begin nerr++; $display("FAIL resp_reset_table: got %b/%0d want 0000/0", lock_valid, num_locked); end
    reset = 1'b1;
    @(posedge clk); #1;
    nchk++; if ({acq_grant, lock_valid} !== 6'b0) begin nerr++; $display("FAIL resp_reset_after: got %b want 000000", {acq_grant, lock_valid}); end
    do_acq(0, 32'h0, lat, g, d);
    nchk++; if ({g, lat, lock_valid, locked_key[31:0]} !== {1'b1, 32'd3, 4'b0001, 32'h0}) begin nerr++; $display("FAIL zero_key: got g%b lat %0d %b %h want g1 lat 3 0001 0", g, lat, lock_valid, locked_key[31:0]); end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_same_key();
    test_full_and_release();
    test_rel_miss();
    test_back_to_back_release();
    test_rel_priority();
    test_owner();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
